// File: rtl/cart_wp_pkg.sv
// Shared constants for the cartridge watchpoint unit: register-window layout,
// control/status bit positions and the masked address comparator.
package cart_wp_pkg;

  localparam logic [1:0] SUB_ADDR_HI = 2'd0;
  localparam logic [1:0] SUB_ADDR_LO = 2'd1;
  localparam logic [1:0] SUB_MASK_LO = 2'd2;
  localparam logic [1:0] SUB_CTRL    = 2'd3;

  localparam logic [2:0] STATUS_CH  = 3'd7;
  localparam logic [1:0] SUB_STATUS = 2'd0;
  localparam logic [1:0] SUB_CNT_RD = 2'd1;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_MATCH_RD   = 1;
  localparam int CTRL_MATCH_WR   = 2;
  localparam int CTRL_PRESET_LSB = 8;
  localparam int STATUS_ARMED    = 15;

  typedef struct packed {
    logic en;
    logic match_rd;
    logic match_wr;
  } wp_ctrl_t;

  // A mask bit of 1 means the corresponding address bit takes part in the compare.
  function automatic logic wp_addr_hit(input logic [23:1] bus_addr,
                                       input logic [23:1] cmp_addr,
                                       input logic [23:1] cmp_mask);
    return ((bus_addr ^ cmp_addr) & cmp_mask) == 23'h0;
  endfunction

endpackage

// File: rtl/cart_wp_channel.sv
// One watchpoint channel: address/mask/control registers, hit down-counter and
// comparator. Produces a combinational fire strobe and the addressed read word.
module cart_wp_channel
  import cart_wp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [1:0]       sub,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [15:0]      wr_data,
  input  logic             match_en,
  input  logic [23:1]      cpu_address,
  input  logic             cpu_rd,
  output logic             fire,
  output logic [15:0]      rd_word,
  output logic [CNT_W-1:0] count
);

  logic [23:1]      addr_q, addr_d;
  logic [23:1]      mask_q, mask_d;
  wp_ctrl_t         ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qual;

  assign qual  = match_en & ctrl_q.en & wp_addr_hit(cpu_address, addr_q, mask_q)
               & (cpu_rd ? ctrl_q.match_rd : ctrl_q.match_wr);
  assign fire  = qual & (cnt_q == '0);
  assign count = cnt_q;

  always_comb begin
    addr_d   = addr_q;
    mask_d   = mask_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    if (qual) begin
      cnt_d = (cnt_q == '0) ? preset_q : cnt_q - CNT_W'(1);
    end
    // Register writes come last so a control write overrides any counter update.
    if (wr_en) begin
      case (sub)
        SUB_ADDR_HI: begin
          if (wr_hi) mask_d[23:16] = wr_data[15:8];
          if (wr_lo) addr_d[23:16] = wr_data[7:0];
        end
        SUB_ADDR_LO: begin
          if (wr_hi) addr_d[15:8] = wr_data[15:8];
          if (wr_lo) addr_d[7:1]  = wr_data[7:1];
        end
        SUB_MASK_LO: begin
          if (wr_hi) mask_d[15:8] = wr_data[15:8];
          if (wr_lo) mask_d[7:1]  = wr_data[7:1];
        end
        default: begin
          if (wr_lo) begin
            ctrl_d.en       = wr_data[CTRL_EN];
            ctrl_d.match_rd = wr_data[CTRL_MATCH_RD];
            ctrl_d.match_wr = wr_data[CTRL_MATCH_WR];
          end
          if (wr_hi) preset_d = wr_data[CTRL_PRESET_LSB +: CNT_W];
          cnt_d = preset_d;
        end
      endcase
    end
  end

  always_comb begin
    rd_word = 16'h0000;
    case (sub)
      SUB_ADDR_HI: rd_word = {mask_q[23:16], addr_q[23:16]};
      SUB_ADDR_LO: rd_word = {addr_q[15:1], 1'b0};
      SUB_MASK_LO: rd_word = {mask_q[15:1], 1'b0};
      default: begin
        rd_word[CTRL_EN]                     = ctrl_q.en;
        rd_word[CTRL_MATCH_RD]               = ctrl_q.match_rd;
        rd_word[CTRL_MATCH_WR]               = ctrl_q.match_wr;
        rd_word[CTRL_PRESET_LSB +: CNT_W]    = preset_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      preset_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cart_watchpoint_unit.sv
// NUM_WP-channel address watchpoint beside the cartridge controller: bus-cycle
// detection, arming, sticky hit flags, status/counter window and read mux.
module cart_watchpoint_unit
  import cart_wp_pkg::*;
#(
  parameter int NUM_WP = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic [23:1]       cpu_address,
  input  logic              _cpu_as,
  input  logic              cpu_rd,
  input  logic              cpu_hwr,
  input  logic              cpu_lwr,
  input  logic              dbr,
  input  logic              active,
  input  logic              reg_sel,
  input  logic [5:1]        reg_address,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  input  logic              rearm,
  output logic              brk_req,
  output logic [NUM_WP-1:0] hit
);

  logic              as_q, as_d;
  logic              armed_q, armed_d;
  logic              brk_q, brk_d;
  logic [NUM_WP-1:0] hit_q, hit_d;
  logic [2:0]        cnt_idx_q, cnt_idx_d;

  logic              cycle_start;
  logic              match_en;
  logic              reg_wr;
  logic              status_wr;
  logic              cnt_idx_wr;
  logic [2:0]        ch_sel;
  logic [1:0]        sub_sel;
  logic [15:0]       rd_word;

  logic [NUM_WP-1:0] fire;
  logic [15:0]       ch_rd  [NUM_WP];
  logic [CNT_W-1:0]  ch_cnt [NUM_WP];

  assign ch_sel      = reg_address[5:3];
  assign sub_sel     = reg_address[2:1];
  assign cycle_start = as_q & ~_cpu_as & ~dbr;
  assign match_en    = cycle_start & armed_q & ~active;
  assign reg_wr      = reg_sel & (cpu_hwr | cpu_lwr);
  assign status_wr   = reg_wr & (ch_sel == STATUS_CH) & (sub_sel == SUB_STATUS);
  assign cnt_idx_wr  = reg_wr & (ch_sel == STATUS_CH) & (sub_sel == SUB_CNT_RD);

  for (genvar g = 0; g < NUM_WP; g++) begin : g_ch
    cart_wp_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset_n     (_reset),
      .wr_en       (reg_wr & (ch_sel == 3'(g))),
      .sub         (sub_sel),
      .wr_hi       (cpu_hwr),
      .wr_lo       (cpu_lwr),
      .wr_data     (data_in),
      .match_en    (match_en),
      .cpu_address (cpu_address),
      .cpu_rd      (cpu_rd),
      .fire        (fire[g]),
      .rd_word     (ch_rd[g]),
      .count       (ch_cnt[g])
    );
  end

  // A fresh fire outranks a W1C clear of the same bit and any re-arm request.
  always_comb begin
    as_d      = _cpu_as;
    brk_d     = |fire;
    hit_d     = hit_q;
    armed_d   = armed_q;
    cnt_idx_d = cnt_idx_q;
    if (status_wr && cpu_lwr) hit_d = hit_q & ~data_in[NUM_WP-1:0];
    if (status_wr && cpu_hwr && data_in[STATUS_ARMED]) armed_d = 1'b1;
    if (rearm) armed_d = 1'b1;
    if (cnt_idx_wr && cpu_lwr) cnt_idx_d = data_in[2:0];
    hit_d = hit_d | fire;
    if (|fire) armed_d = 1'b0;
  end

  always_comb begin
    rd_word = 16'h0000;
    if (ch_sel == STATUS_CH) begin
      if (sub_sel == SUB_STATUS) begin
        rd_word[NUM_WP-1:0]   = hit_q;
        rd_word[STATUS_ARMED] = armed_q;
      end else if (sub_sel == SUB_CNT_RD) begin
        for (int i = 0; i < NUM_WP; i++) begin
          if (cnt_idx_q == 3'(i)) rd_word[CNT_W-1:0] = ch_cnt[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_WP; i++) begin
        if (ch_sel == 3'(i)) rd_word = ch_rd[i];
      end
    end
  end

  assign data_out = (reg_sel & cpu_rd) ? rd_word : 16'h0000;
  assign brk_req  = brk_q;
  assign hit      = hit_q;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      as_q      <= 1'b1;
      armed_q   <= 1'b0;
      brk_q     <= 1'b0;
      hit_q     <= '0;
      cnt_idx_q <= '0;
    end else begin
      as_q      <= as_d;
      armed_q   <= armed_d;
      brk_q     <= brk_d;
      hit_q     <= hit_d;
      cnt_idx_q <= cnt_idx_d;
    end
  end

endmodule
